// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, one lane-aware write port, post-reset clear.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_param #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 3,
  parameter bit ZERO_REG0 = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd1,
  input  logic              wn1,
  input  logic              rd2,
  input  logic              wn2,
  input  logic              rd3,
  input  logic              wn3,
  input  logic [1:0]        write_mode,
  input  logic [ADDR_W-1:0] reg_id1,
  input  logic [ADDR_W-1:0] reg_id2,
  input  logic [ADDR_W-1:0] reg_id3,
  input  logic [DATA_W-1:0] write_data3,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              ready,
  output logic              write_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int L     = DATA_W / 2;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_req, wr_drop, wr_en;
  logic [DATA_W-1:0] wr_value;

  assign wr_req  = !rd3 && wn3;
  assign wr_drop = ZERO_REG0 && (reg_id3 == '0);
  assign wr_en   = wr_req && ready && !wr_drop && !reset;

  // Post-write image of the addressed entry; lane modes keep the untouched half.
  always_comb begin
    wr_value = mem[reg_id3];
    case (write_mode)
      2'b00: wr_value = write_data3;
      2'b01: wr_value[L-1:0] = write_data3[L-1:0];
      2'b10: wr_value[DATA_W-1:L] = write_data3[L-1:0];
      default: wr_value = {{L{write_data3[L-1]}}, write_data3[L-1:0]};
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR: if (clr_idx == ADDR_W'(DEPTH - 1)) state_next = READY;
      READY: state_next = READY;
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      clr_idx   <= '0;
      ready     <= 1'b0;
      write_err <= 1'b0;
    end else begin
      state     <= state_next;
      ready     <= (state_next == READY);
      write_err <= wr_req && !ready;
      if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
    end
  end

  // Storage has no reset of its own; the CLEAR walk zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (!reset && state == CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (wr_en) begin
      mem[reg_id3] <= wr_value;
    end
  end

  always_comb begin
    read_data1 = '0;
    if (ready && rd1 && !wn1 && !(ZERO_REG0 && reg_id1 == '0)) begin
      read_data1 = mem[reg_id1];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && reg_id1 == reg_id3) read_data1 = wr_value;
`endif
    end
  end

  always_comb begin
    read_data2 = '0;
    if (ready && rd2 && !wn2 && !(ZERO_REG0 && reg_id2 == '0)) begin
      read_data2 = mem[reg_id2];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && reg_id2 == reg_id3) read_data2 = wr_value;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: two instances (ZERO_REG0 = 0 and 1) driven in lockstep
// against an array-based reference model.
module tb_regfile_param;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  typedef struct packed {
    logic        reset, rd1, wn1, rd2, wn2, rd3, wn3;
    logic [1:0]  mode;
    logic [2:0]  id1, id2, id3;
    logic [15:0] wd;
  } stim_t;

  typedef struct packed {
    logic [15:0] r1p, r2p, r1z, r2z;
    logic        rdy, err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, rd1, wn1, rd2, wn2, rd3, wn3;
  logic [1:0]  write_mode;
  logic [2:0]  reg_id1, reg_id2, reg_id3;
  logic [15:0] write_data3;
  logic [15:0] read_data1_p, read_data2_p, read_data1_z, read_data2_z;
  logic        ready_p, ready_z, write_err_p, write_err_z;

  regfile_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG0(1'b0)) u_plain (
    .clk(clk), .reset(reset), .rd1(rd1), .wn1(wn1), .rd2(rd2), .wn2(wn2),
    .rd3(rd3), .wn3(wn3), .write_mode(write_mode), .reg_id1(reg_id1),
    .reg_id2(reg_id2), .reg_id3(reg_id3), .write_data3(write_data3),
    .read_data1(read_data1_p), .read_data2(read_data2_p),
    .ready(ready_p), .write_err(write_err_p));

  regfile_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG0(1'b1)) u_zero (
    .clk(clk), .reset(reset), .rd1(rd1), .wn1(wn1), .rd2(rd2), .wn2(wn2),
    .rd3(rd3), .wn3(wn3), .write_mode(write_mode), .reg_id1(reg_id1),
    .reg_id2(reg_id2), .reg_id3(reg_id3), .write_data3(write_data3),
    .read_data1(read_data1_z), .read_data2(read_data2_z),
    .ready(ready_z), .write_err(write_err_z));

  logic [15:0] mem_plain [DEPTH];
  logic [15:0] mem_zero  [DEPTH];
  bit          m_ready, m_err;
  int          m_cnt;
  exp_t        sb [$];
  int          checks = 0;
  int          passed = 0;

  function automatic logic [15:0] merged(logic [15:0] old, logic [1:0] mode, logic [15:0] wd);
    case (mode)
      2'd0: return wd;
      2'd1: return (old & 16'hFF00) | (wd & 16'h00FF);
      2'd2: return (old & 16'h00FF) | ((wd & 16'h00FF) << 8);
      default: return (wd & 16'h0080) != 0 ? ((wd & 16'h00FF) | 16'hFF00) : (wd & 16'h00FF);
    endcase
  endfunction

  function automatic logic [15:0] exp_read(bit zero, logic en, logic wn, logic [2:0] id, stim_t s);
    logic [15:0] v;
    if (!m_ready || !en || wn) return 16'h0;
    if (zero && id == 3'd0) return 16'h0;
    v = zero ? mem_zero[id] : mem_plain[id];
`ifdef REGFILE_BYPASS_EN
    if (!s.reset && !s.rd3 && s.wn3 && s.id3 == id) v = merged(v, s.mode, s.wd);
`else
    if (s.reset && s.wd == 16'h0 && s.id3 == 3'd7) v = v;
`endif
    return v;
  endfunction

  task automatic model_edge(stim_t s);
    bit qual;
    qual = !s.rd3 && s.wn3;
    if (s.reset) begin
      m_ready = 1'b0;
      m_err   = 1'b0;
      m_cnt   = 0;
    end else begin
      m_err = qual && !m_ready;
      if (m_ready) begin
        if (qual) begin
          mem_plain[s.id3] = merged(mem_plain[s.id3], s.mode, s.wd);
          if (s.id3 != 3'd0) mem_zero[s.id3] = merged(mem_zero[s.id3], s.mode, s.wd);
        end
      end else begin
        m_cnt++;
        if (m_cnt == DEPTH) begin
          m_ready = 1'b1;
          for (int i = 0; i < DEPTH; i++) begin
            mem_plain[i] = 16'h0;
            mem_zero[i]  = 16'h0;
          end
        end
      end
    end
  endtask

  task automatic applyStimulus(stim_t s);
    exp_t e;
    reset = s.reset; rd1 = s.rd1; wn1 = s.wn1; rd2 = s.rd2; wn2 = s.wn2;
    rd3 = s.rd3; wn3 = s.wn3; write_mode = s.mode;
    reg_id1 = s.id1; reg_id2 = s.id2; reg_id3 = s.id3; write_data3 = s.wd;
    e.r1p = exp_read(1'b0, s.rd1, s.wn1, s.id1, s);
    e.r2p = exp_read(1'b0, s.rd2, s.wn2, s.id2, s);
    e.r1z = exp_read(1'b1, s.rd1, s.wn1, s.id1, s);
    e.r2z = exp_read(1'b1, s.rd2, s.wn2, s.id2, s);
    e.rdy = m_ready;
    e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    model_edge(s);
    #1;
  endtask

  task automatic checkOutput(string name, logic [15:0] actual, logic [15:0] required);
    checks++;
    if (actual !== required)
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
    else
      passed++;
  endtask

  // Monitor: one expected entry is queued per cycle; compare mid-cycle at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("read_data1_plain", read_data1_p, e.r1p);
        checkOutput("read_data2_plain", read_data2_p, e.r2p);
        checkOutput("read_data1_zero",  read_data1_z, e.r1z);
        checkOutput("read_data2_zero",  read_data2_z, e.r2z);
        checkOutput("ready_plain",      {15'h0, ready_p}, {15'h0, e.rdy});
        checkOutput("ready_zero",       {15'h0, ready_z}, {15'h0, e.rdy});
        checkOutput("write_err_plain",  {15'h0, write_err_p}, {15'h0, e.err});
        checkOutput("write_err_zero",   {15'h0, write_err_z}, {15'h0, e.err});
      end
    end
  end

  function automatic stim_t s_rd(logic [2:0] id1, logic [2:0] id2);
    stim_t s;
    s = '0;
    s.rd1 = 1'b1; s.rd2 = 1'b1; s.id1 = id1; s.id2 = id2;
    return s;
  endfunction

  function automatic stim_t s_wr(logic [2:0] id3, logic [1:0] mode, logic [15:0] wd, logic [2:0] rid);
    stim_t s;
    s = s_rd(rid, rid);
    s.wn3 = 1'b1; s.id3 = id3; s.mode = mode; s.wd = wd;
    return s;
  endfunction

  function automatic stim_t s_reset();
    stim_t s;
    s = s_rd(3'd0, 3'd0);
    s.reset = 1'b1;
    return s;
  endfunction

  initial begin
    stim_t s;
    reset = 1'b1; rd1 = 1'b0; wn1 = 1'b0; rd2 = 1'b0; wn2 = 1'b0;
    rd3 = 1'b0; wn3 = 1'b0; write_mode = 2'd0;
    reg_id1 = '0; reg_id2 = '0; reg_id3 = '0; write_data3 = '0;
    repeat (2) @(posedge clk);
    #1;
    m_ready = 1'b0; m_err = 1'b0; m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mem_plain[i] = 16'h0;
      mem_zero[i]  = 16'h0;
    end

    // Initial clear, then preload every entry.
    for (int i = 0; i < DEPTH; i++) applyStimulus(s_rd(3'(i), 3'(i)));
    for (int i = 0; i < DEPTH; i++) applyStimulus(s_wr(3'(i), 2'd0, 16'(16'h1111 * (i + 1)), 3'(i)));
    for (int i = 0; i < DEPTH; i++) applyStimulus(s_rd(3'(i), 3'(DEPTH - 1 - i)));

    // Single-cycle reset, write attempt in the third clear cycle, then read everything back.
    applyStimulus(s_reset());
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(i == 2 ? s_wr(3'd4, 2'd0, 16'hAAAA, 3'd4) : s_rd(3'd4, 3'd1));
    for (int i = 0; i < DEPTH; i++) applyStimulus(s_rd(3'(i), 3'(i)));

    // Lane modes on r3.
    applyStimulus(s_wr(3'd3, 2'd0, 16'h1234, 3'd3));
    applyStimulus(s_rd(3'd3, 3'd3));
    applyStimulus(s_wr(3'd3, 2'd1, 16'h00AB, 3'd3));
    applyStimulus(s_rd(3'd3, 3'd3));
    applyStimulus(s_wr(3'd3, 2'd2, 16'h00CD, 3'd3));
    applyStimulus(s_rd(3'd3, 3'd3));
    applyStimulus(s_wr(3'd3, 2'd3, 16'h0080, 3'd3));
    applyStimulus(s_rd(3'd3, 3'd3));
    applyStimulus(s_wr(3'd3, 2'd3, 16'h007F, 3'd3));
    applyStimulus(s_rd(3'd3, 3'd3));

    // Entry 0 protection and dual reads, including a write-inhibited port 2.
    applyStimulus(s_wr(3'd0, 2'd0, 16'hBEEF, 3'd7));
    applyStimulus(s_wr(3'd7, 2'd0, 16'h5555, 3'd0));
    applyStimulus(s_rd(3'd0, 3'd0));
    applyStimulus(s_rd(3'd7, 3'd7));
    s = s_rd(3'd7, 3'd7);
    s.wn2 = 1'b1;
    applyStimulus(s);

    // Same-cycle read of the address being written.
    applyStimulus(s_wr(3'd5, 2'd0, 16'h1111, 3'd0));
    applyStimulus(s_wr(3'd5, 2'd0, 16'h2222, 3'd5));
    applyStimulus(s_rd(3'd5, 3'd5));

    // Reset part-way through the clear walk.
    applyStimulus(s_reset());
    for (int i = 0; i < 4; i++) applyStimulus(s_rd(3'd2, 3'd6));
    applyStimulus(s_reset());
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(s_rd(3'(i), 3'd5));

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      s.reset = ($urandom_range(0, 99) == 0);
      s.rd1   = ($urandom_range(0, 3) != 0);
      s.wn1   = ($urandom_range(0, 3) == 0);
      s.rd2   = ($urandom_range(0, 3) != 0);
      s.wn2   = ($urandom_range(0, 3) == 0);
      s.rd3   = ($urandom_range(0, 3) == 0);
      s.wn3   = ($urandom_range(0, 1) == 1);
      s.mode  = 2'($urandom_range(0, 3));
      s.id1   = 3'($urandom_range(0, 7));
      s.id2   = 3'($urandom_range(0, 7));
      s.id3   = ($urandom_range(0, 1) == 1) ? s.id1 : 3'($urandom_range(0, 7));
      s.wd    = 16'($urandom);
      if (!m_ready && s.id3 == 3'd0) s.id3 = 3'd1;
      applyStimulus(s);
    end

    checks++;
    if (sb.size() != 0)
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sb.size());
    else
      passed++;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
Parametrised successor of the 16-bit, 8-entry general-purpose register file in the core datapath.
- Generalised data width and depth.
- Two combinational read ports and one synchronous write port with half-word lane modes, including sign-extending low-half writes.
- A post-reset clearing state machine that zeroes every entry before the file reports ready.
- Sits between decode (read addresses) and writeback (write port).

Parameters:
DATA_W, 16, register width in bits; must be even (lane = DATA_W/2).
ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries.
ZERO_REG0, 0, when 1 entry 0 always reads zero and ignores writes.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
rd1  input  1  read enable, port 1
wn1  input  1  write-inhibit qualifier, port 1 (read valid only when rd1=1, wn1=0)
rd2  input  1  read enable, port 2
wn2  input  1  write-inhibit qualifier, port 2 (read valid only when rd2=1, wn2=0)
rd3  input  1  must be 0 for a write to occur
wn3  input  1  write enable (write when rd3=0, wn3=1)
write_mode  input  2  00 full, 01 low lane, 10 high lane, 11 low lane sign-extended
reg_id1  input  ADDR_W  read address, port 1
reg_id2  input  ADDR_W  read address, port 2
reg_id3  input  ADDR_W  write address
write_data3  input  DATA_W  write data (lane modes use bits [DATA_W/2-1:0])
read_data1  output  DATA_W  read data, port 1
read_data2  output  DATA_W  read data, port 2
ready  output  1  1 once clearing is complete
write_err  output  1  registered one-cycle pulse: write requested while not ready

Behaviour:
- Clock is clk. Reset is synchronous and active-high on port reset.
- FSM has two states: CLEAR and READY.
  - Reset (any state, including mid-clear): next state CLEAR, clr_idx <= 0, ready <= 0, write_err <= 0.
  - In CLEAR: each cycle mem[clr_idx] <= 0 and clr_idx increments. When clr_idx == DEPTH-1, next state is READY and ready <= 1.
  - ready rises exactly DEPTH cycles after the cycle reset is sampled deasserted.
  - READY is held until the next reset.
- Reads are combinational. read_dataN = mem[reg_idN] when rdN=1, wnN=0 and ready=1; otherwise 0.
  - With ZERO_REG0=1, address 0 always reads 0.
  - Reads return 0 throughout reset and CLEAR.
- Write qualifier: rd3=0 and wn3=1, sampled at the rising edge.
  - Ignored while not ready; write_err pulses high for the following cycle. Any other case drives write_err to 0 next cycle.
  - ZERO_REG0=1 with reg_id3=0: write silently dropped, no error.
- Write modes (L = DATA_W/2):
  - 00: mem <= write_data3.
  - 01: mem[L-1:0] <= write_data3[L-1:0]; upper half is kept.
  - 10: mem[DATA_W-1:L] <= write_data3[L-1:0]; lower half is kept.
  - 11: mem <= {L copies of write_data3[L-1], write_data3[L-1:0]}.
- Write-to-read latency without bypass: the new value is visible on read ports in the cycle after the write edge. A same-cycle read of the written address returns the old value.
- Both read ports may address the same entry, or the write address, simultaneously; no conflict.
- Address space is exactly DEPTH, so no out-of-range case exists.

Optional Feature:
Macro: REGFILE_BYPASS_EN.
- Defined: when a qualified write (ready=1, not dropped by ZERO_REG0) targets the same address a port is reading in the same cycle, that port returns the merged post-write value combinationally. Merge follows write_mode, e.g. mode 01 returns {old upper half, new low lane}.
- Undefined: reads return stored contents only (one-cycle write-to-read latency).

Test Plan:
- Clear sequence: preload via writes, assert reset 1 cycle, release → ready=0 for 8 cycles then 1. All 8 entries read 0x0000; read_data1 is 0 during CLEAR regardless of rd1.
- Lane modes: write 0x1234 mode 00 to r3, then 0x00AB mode 01, then 0x00CD mode 10 → r3 reads 0x1234, 0x12AB, 0xCDAB. Write 0x0080 mode 11 → 0xFF80; write 0x007F mode 11 → 0x007F.
- Write during clear: wn3=1, rd3=0 in 3rd CLEAR cycle → write_err=1 for exactly one cycle; entry reads 0 after ready.
- Reset mid-clear: reset asserted after 4 CLEAR cycles → clr_idx restarts; ready rises 8 cycles after release.
- Dual read / ZERO_REG0=1: write 0xBEEF to r0 and 0x5555 to r7 → both ports reading r0 return 0x0000, no write_err; r7 returns 0x5555 on both ports; rd2=1, wn2=1 returns 0.
- Same-cycle read/write of r5 (old 0x1111, write 0x2222 mode 00) → read_data1 = 0x1111 without REGFILE_BYPASS_EN, 0x2222 with it; next cycle 0x2222 in both builds.
